// File: rtl/fetch_sequencer_if.sv
// Instruction memory / program loader bus.
// master: the fetch sequencer. It drives mem_addr and ld_gnt, and receives
//         mem_data, ld_req and ld_addr.
// slave : the memory/loader side. It drives mem_data, ld_req and ld_addr.
interface fetch_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  ld_req;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic                  ld_gnt;

    modport master (output mem_addr, output ld_gnt,
                    input  mem_data, input  ld_req, input ld_addr);
    modport slave  (input  mem_addr, input  ld_gnt,
                    output mem_data, output ld_req, output ld_addr);
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC and drives the address of a combinational-read
// instruction memory. Each fetched word is registered into IF/ID. The block
// handles stall, branch redirect and halt, and hands the address bus to an
// external program loader while idle.
// Ports:
//   clk, reset          single clock, async active-high reset
//   start               begin/restart fetch (sampled in IDLE and HALT)
//   stall, redirect     decode hazard hold / taken branch with br_target
//   bus (master)        mem_addr/mem_data memory port, ld_req/ld_addr/ld_gnt loader
//   if_id_*             registered instruction, its PC, valid flag
//   pc, halted          current fetch PC, HALT-state flag
//   fetch_cnt           saturating count of valid instructions latched
module fetch_sequencer #(
    parameter int                   DATA_WIDTH  = 16,
    parameter int                   ADDR_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 8'h00,
    parameter logic [3:0]           HALT_OPCODE = 4'b1111,
    parameter int                   CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] br_target,
    fetch_sequencer_if.master     bus,
    output logic [DATA_WIDTH-1:0] if_id_instr,
    output logic [ADDR_WIDTH-1:0] if_id_pc,
    output logic                  if_id_valid,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  fetch_cnt
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;
    state_t state;

    logic is_halt;
    assign is_halt = (bus.mem_data[DATA_WIDTH-1:DATA_WIDTH-4] == HALT_OPCODE);

    // The address mux is combinational, so a reset forces mem_addr back to pc
    // (= RESET_PC) immediately.
    assign bus.mem_addr = (state == LOAD) ? bus.ld_addr : pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            if_id_instr <= '0;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
            bus.ld_gnt  <= 1'b0;
            halted      <= 1'b0;
            fetch_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // The loader wins over start.
                    if (bus.ld_req) begin
                        state      <= LOAD;
                        bus.ld_gnt <= 1'b1;
                    end else if (start) begin
                        state <= RUN;
                    end
                end
                LOAD: begin
                    if (!bus.ld_req) begin
                        state      <= IDLE;
                        bus.ld_gnt <= 1'b0;
                    end
                end
                RUN: begin
                    if (redirect) begin
                        // A redirect squashes the in-flight slot even under stall.
                        pc          <= br_target;
                        if_id_valid <= 1'b0;
                        if_id_instr <= '0;
                    end else if (!stall) begin
                        if_id_instr <= bus.mem_data;
                        if_id_pc    <= pc;
                        if_id_valid <= 1'b1;
                        if (fetch_cnt != '1)
                            fetch_cnt <= fetch_cnt + 1'b1;
                        if (is_halt) begin
                            // The halt word itself is delivered. The PC parks on it.
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end
                end
                HALT: begin
                    if (start) begin
                        state       <= RUN;
                        pc          <= RESET_PC;
                        halted      <= 1'b0;
                        if_id_instr <= '0;
                        if_id_pc    <= '0;
                        if_id_valid <= 1'b0;
                    end else if (!stall) begin
                        if_id_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        reset, start, stall, redirect;
    logic [7:0]  br_target;
    logic [15:0] if_id_instr;
    logic [7:0]  if_id_pc, pc;
    logic        if_id_valid, halted;
    logic [15:0] fetch_cnt;
    logic [15:0] mem [0:255];
    int          n_cmp = 0;
    int          n_err = 0;

    fetch_sequencer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .redirect(redirect), .br_target(br_target), .bus(bus),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
        .pc(pc), .halted(halted), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;
    assign bus.mem_data = mem[bus.mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);
        reset = 1'b1; start = 1'b0; stall = 1'b0; redirect = 1'b0; br_target = 8'h00;
        bus.ld_req = 1'b0; bus.ld_addr = 8'h00;
        #12;
        chk("rst_pc", pc, 8'h00);
        chk("rst_mem_addr", bus.mem_addr, 8'h00);
        chk("rst_valid", if_id_valid, 0);
        chk("rst_gnt", bus.ld_gnt, 0);
        chk("rst_halted", halted, 0);
        chk("rst_cnt", fetch_cnt, 0);
        step(); reset = 1'b0;

        // Start fetch. The first word is latched two edges after start is seen.
        start = 1'b1; step(); start = 1'b0;
        chk("t1_pc0", pc, 8'h00);
        chk("t1_valid0", if_id_valid, 0);
        step(); chk("t1_ifpc0", if_id_pc, 8'h00); chk("t1_instr0", if_id_instr, 16'h0100);
        step(); chk("t1_ifpc1", if_id_pc, 8'h01);
        step(); chk("t1_ifpc2", if_id_pc, 8'h02);
        bus.ld_req = 1'b1;
        step(); chk("t1_ifpc3", if_id_pc, 8'h03); chk("t1_valid", if_id_valid, 1);
        chk("t1_cnt", fetch_cnt, 4); chk("t1_ld_ignored", bus.ld_gnt, 0);
        bus.ld_req = 1'b0;

        // Stall for two cycles at pc=5.
        step(); chk("t2_pc5", pc, 8'h05); chk("t2_cnt5", fetch_cnt, 5);
        stall = 1'b1;
        step(); chk("t2_s1_pc", pc, 8'h05); chk("t2_s1_ifpc", if_id_pc, 8'h04); chk("t2_s1_cnt", fetch_cnt, 5);
        step(); chk("t2_s2_pc", pc, 8'h05); chk("t2_s2_instr", if_id_instr, 16'h0104); chk("t2_s2_cnt", fetch_cnt, 5);
        stall = 1'b0;
        step(); chk("t2_rel_ifpc", if_id_pc, 8'h05); chk("t2_rel_pc", pc, 8'h06); chk("t2_rel_cnt", fetch_cnt, 6);

        // Redirect to 3, then redirect+stall to 0x40. The redirect wins.
        redirect = 1'b1; br_target = 8'h03;
        step(); chk("t3_pc3", pc, 8'h03); chk("t3_bubble", if_id_valid, 0);
        stall = 1'b1; br_target = 8'h40;
        step(); chk("t3_pc40", pc, 8'h40); chk("t3_valid0", if_id_valid, 0);
        chk("t3_instr0", if_id_instr, 0); chk("t3_cnt", fetch_cnt, 6);
        redirect = 1'b0; stall = 1'b0;
        step(); chk("t3_ifpc40", if_id_pc, 8'h40); chk("t3_valid1", if_id_valid, 1);
        chk("t3_instr40", if_id_instr, 16'h0140); chk("t3_pc41", pc, 8'h41);

        // PC wraps from 0xFF to 0x00.
        redirect = 1'b1; br_target = 8'hFF;
        step(); chk("t6_pcff", pc, 8'hFF); redirect = 1'b0;
        step(); chk("t6_ifpcff", if_id_pc, 8'hFF); chk("t6_wrap", pc, 8'h00); chk("t6_cnt", fetch_cnt, 8);

        // Halt at mem[2].
        mem[2] = 16'hF000;
        step(); chk("t5_ifpc0", if_id_pc, 8'h00);
        step(); chk("t5_pc2", pc, 8'h02); chk("t5_cnt10", fetch_cnt, 10);
        step(); chk("t5_hinstr", if_id_instr, 16'hF000); chk("t5_hvalid", if_id_valid, 1);
        chk("t5_halted", halted, 1); chk("t5_pcfrozen", pc, 8'h02); chk("t5_cnt11", fetch_cnt, 11);
        step(); chk("t5_drain", if_id_valid, 0); chk("t5_halted2", halted, 1); chk("t5_pc2b", pc, 8'h02);
        step(); chk("t5_pc2c", pc, 8'h02); chk("t5_cnt_hold", fetch_cnt, 11);
        start = 1'b1;
        step(); start = 1'b0;
        chk("t5_restart_pc", pc, 8'h00); chk("t5_unhalt", halted, 0);
        chk("t5_clr_valid", if_id_valid, 0); chk("t5_clr_instr", if_id_instr, 0);
        chk("t5_cnt_kept", fetch_cnt, 11);
        step(); chk("t5_refetch", if_id_pc, 8'h00); chk("t5_cnt12", fetch_cnt, 12);

        // Back to IDLE through reset, then ld_req beats start.
        #2 reset = 1'b1; #1;
        chk("t4_rst_cnt", fetch_cnt, 0);
        reset = 1'b0;
        bus.ld_req = 1'b1; start = 1'b1; bus.ld_addr = 8'h22;
        step(); start = 1'b0;
        chk("t4_gnt", bus.ld_gnt, 1); chk("t4_addr22", bus.mem_addr, 8'h22);
        bus.ld_addr = 8'h33; #1;
        chk("t4_addr33", bus.mem_addr, 8'h33);
        step(); chk("t4_pc_hold", pc, 8'h00); chk("t4_gnt2", bus.ld_gnt, 1);
        bus.ld_req = 1'b0;
        step(); chk("t4_ungnt", bus.ld_gnt, 0); chk("t4_addr_pc", bus.mem_addr, 8'h00);
        step(); chk("t4_idle_valid", if_id_valid, 0); chk("t4_idle_cnt", fetch_cnt, 0);

        // Asynchronous reset while in LOAD.
        bus.ld_req = 1'b1; bus.ld_addr = 8'h55;
        step(); chk("t6_gnt", bus.ld_gnt, 1); chk("t6_addr55", bus.mem_addr, 8'h55);
        #2 reset = 1'b1; #1;
        chk("t6_async_gnt", bus.ld_gnt, 0); chk("t6_async_idle", bus.mem_addr, 8'h00);
        reset = 1'b0; bus.ld_req = 1'b0;
        step(); chk("t6_after_gnt", bus.ld_gnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish, expected finish before 20000");
        $fatal(1, "timeout");
    end
endmodule
